// File: rtl/gpp_boot_ctrl_pkg.sv
// Shared widths, run timeout default and sequencer state type for the GPP boot controller.
package gpp_boot_ctrl_pkg;

  localparam int unsigned GPP_D_WIDTH     = 32;
  localparam int unsigned GPP_SA_WIDTH    = 5;
  localparam int unsigned GPP_SL_WIDTH    = 32;
  localparam int unsigned GPP_TIMEOUT_DEF = 100000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_GRST,
    S_START,
    S_RUN,
    S_DONE
  } boot_state_e;

endpackage

// File: rtl/gpp_boot_ctrl.sv
// GPP boot sequencer: clears instruction SRAM, streams the program in from address 0,
// pulses GPP reset, starts it and supervises the run until Done or timeout.
module gpp_boot_ctrl
  import gpp_boot_ctrl_pkg::*;
#(
  parameter int unsigned D_WIDTH  = GPP_D_WIDTH,
  parameter int unsigned SA_WIDTH = GPP_SA_WIDTH,
  parameter int unsigned SL_WIDTH = GPP_SL_WIDTH,
  parameter int unsigned TIMEOUT  = GPP_TIMEOUT_DEF
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Boot_Req,
  input  logic                Ld_Valid,
  input  logic [D_WIDTH-1:0]  Ld_Data,
  input  logic                Ld_Last,
  output logic                Ld_Ready,
  output logic                Mem_Rst,
  output logic [SA_WIDTH-1:0] Sram_Addr,
  output logic [D_WIDTH-1:0]  Sram_Data,
  output logic                Sram_En,
  output logic                Sram_RW,
  output logic                Gpp_Rst,
  output logic                Gpp_Str,
  input  logic                Gpp_Done,
  output logic                Busy,
  output logic                Run_Done,
  output logic                Err,
  output logic [31:0]         Run_Cycles
);

  localparam int unsigned PTR_W = SA_WIDTH + 1;

  boot_state_e      state_q;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [31:0]      run_cycles_q, run_cycles_d;
  logic             ld_ready_q, mem_rst_q, gpp_rst_q, gpp_str_q;
  logic             busy_q, run_done_q, err_q;
  logic             accept, load_end;

  // Ld_Ready is only ever high in LOAD, so it doubles as the LOAD decode for the write port.
  assign accept       = Ld_Valid & ld_ready_q;
  assign load_end     = Ld_Last | (ptr_q == PTR_W'(SL_WIDTH - 1));
  assign ptr_d        = ptr_q + PTR_W'(1);
  assign run_cycles_d = run_cycles_q + 32'd1;

  assign Sram_En    = accept;
  assign Sram_RW    = accept;
  assign Sram_Data  = accept ? Ld_Data : '0;
  assign Sram_Addr  = ld_ready_q ? ptr_q[SA_WIDTH-1:0] : '0;
  assign Ld_Ready   = ld_ready_q;
  assign Mem_Rst    = mem_rst_q;
  assign Gpp_Rst    = gpp_rst_q;
  assign Gpp_Str    = gpp_str_q;
  assign Busy       = busy_q;
  assign Run_Done   = run_done_q;
  assign Err        = err_q;
  assign Run_Cycles = run_cycles_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      run_cycles_q <= '0;
      ld_ready_q   <= 1'b0;
      mem_rst_q    <= 1'b0;
      gpp_rst_q    <= 1'b1;
      gpp_str_q    <= 1'b0;
      busy_q       <= 1'b0;
      run_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (Boot_Req) begin
            state_q      <= S_CLR;
            mem_rst_q    <= 1'b1;
            busy_q       <= 1'b1;
            ptr_q        <= '0;
            run_cycles_q <= '0;
            run_done_q   <= 1'b0;
            err_q        <= 1'b0;
          end
        end
        S_CLR: begin
          state_q    <= S_LOAD;
          mem_rst_q  <= 1'b0;
          ld_ready_q <= 1'b1;
        end
        S_LOAD: begin
          if (accept) begin
            ptr_q <= ptr_d;
            if (load_end) begin
              state_q    <= S_GRST;
              ld_ready_q <= 1'b0;
            end
          end
        end
        S_GRST: begin
          state_q   <= S_START;
          gpp_rst_q <= 1'b0;
          gpp_str_q <= 1'b1;
        end
        S_START: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          run_cycles_q <= run_cycles_d;
          // Done is checked first so a same-cycle Done and timeout finishes cleanly.
          if (Gpp_Done || (run_cycles_d == 32'(TIMEOUT))) begin
            state_q    <= S_DONE;
            gpp_str_q  <= 1'b0;
            gpp_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            run_done_q <= 1'b1;
            err_q      <= ~Gpp_Done;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpp_boot_ctrl.sv
// Randomized scenario bench for gpp_boot_ctrl with a behavioural load/run reference.
module tb_gpp_boot_ctrl;

  localparam int DW  = 32;
  localparam int SAW = 5;
  localparam int SLW = 32;
  localparam int TO  = 16;

  logic          Clk = 1'b0;
  logic          Rst, Boot_Req, Ld_Valid, Ld_Last, Gpp_Done;
  logic [DW-1:0] Ld_Data;
  logic          Ld_Ready, Mem_Rst, Sram_En, Sram_RW, Gpp_Rst, Gpp_Str;
  logic          Busy, Run_Done, Err;
  logic [SAW-1:0] Sram_Addr;
  logic [DW-1:0]  Sram_Data;
  logic [31:0]    Run_Cycles;

  gpp_boot_ctrl #(.D_WIDTH(DW), .SA_WIDTH(SAW), .SL_WIDTH(SLW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst), .Boot_Req(Boot_Req), .Ld_Valid(Ld_Valid), .Ld_Data(Ld_Data),
    .Ld_Last(Ld_Last), .Ld_Ready(Ld_Ready), .Mem_Rst(Mem_Rst), .Sram_Addr(Sram_Addr),
    .Sram_Data(Sram_Data), .Sram_En(Sram_En), .Sram_RW(Sram_RW), .Gpp_Rst(Gpp_Rst),
    .Gpp_Str(Gpp_Str), .Gpp_Done(Gpp_Done), .Busy(Busy), .Run_Done(Run_Done), .Err(Err),
    .Run_Cycles(Run_Cycles)
  );

  always #5 Clk = ~Clk;

  typedef struct { int addr; logic [DW-1:0] data; } wr_t;
  wr_t           wlog[$];
  logic [DW-1:0] words[$];
  int            errors = 0;
  int            checks = 0;

  // Records every SRAM write the controller issues; inputs are stable around the negedge.
  always @(negedge Clk) begin
    if (Rst && Sram_En && Sram_RW) wlog.push_back('{int'(Sram_Addr), Sram_Data});
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Boot_Req = 1'($urandom); Ld_Valid = 1'($urandom); Ld_Last = 1'($urandom);
      Ld_Data = $urandom; Gpp_Done = 1'($urandom);
      @(negedge Clk);
      checks++;
      if ({Gpp_Rst, Mem_Rst, Sram_En, Sram_RW, Sram_Addr, Gpp_Str, Ld_Ready, Busy, Run_Done, Err}
          !== {1'b1, 13'b0})
        $display("FAIL reset_outputs: got rst=%b mrst=%b en=%b rw=%b addr=%0d str=%b rdy=%b busy=%b rd=%b err=%b, need rst=1 others 0",
                 Gpp_Rst, Mem_Rst, Sram_En, Sram_RW, Sram_Addr, Gpp_Str, Ld_Ready, Busy, Run_Done, Err);
      if ({Gpp_Rst, Mem_Rst, Sram_En, Sram_RW, Sram_Addr, Gpp_Str, Ld_Ready, Busy, Run_Done, Err}
          !== {1'b1, 13'b0}) errors++;
      checks++;
      if (Run_Cycles !== 32'd0) begin
        errors++; $display("FAIL reset_run_cycles: got %0d need 0", Run_Cycles);
      end
    end
    Boot_Req = 0; Ld_Valid = 0; Ld_Last = 0; Gpp_Done = 0;
    step(); Rst = 1'b1;
    step(); step();
    checks++;
    if (Busy !== 1'b0 || Gpp_Rst !== 1'b1 || Mem_Rst !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: got busy=%b rst=%b mrst=%b need 0/1/0", Busy, Gpp_Rst, Mem_Rst);
    end
  endtask

  // Starts a boot from IDLE/DONE and streams words[0..n-1]; returns at the first GRST cycle
  // when the load is expected to finish, otherwise still inside LOAD.
  task automatic boot_and_load(input int n, input bit use_last, input int gap_pct,
                               input bit use_pat, input logic [15:0] pat, input string tag);
    int idx, cyc;
    wlog.delete();
    Boot_Req = 1'b1; step(); Boot_Req = 1'b0;
    checks++;
    if (Mem_Rst !== 1'b1 || Busy !== 1'b1 || Ld_Ready !== 1'b0 || Run_Done !== 1'b0 ||
        Err !== 1'b0 || Run_Cycles !== 32'd0) begin
      errors++;
      $display("FAIL %s_clr: got mrst=%b busy=%b rdy=%b rd=%b err=%b cyc=%0d need 1 1 0 0 0 0",
               tag, Mem_Rst, Busy, Ld_Ready, Run_Done, Err, Run_Cycles);
    end
    step();
    checks++;
    if (Ld_Ready !== 1'b1 || Mem_Rst !== 1'b0) begin
      errors++; $display("FAIL %s_load_entry: got rdy=%b mrst=%b need 1 0", tag, Ld_Ready, Mem_Rst);
    end
    idx = 0; cyc = 0;
    while (idx < n && cyc < 200) begin
      Ld_Valid = use_pat ? pat[cyc % 16] : 1'($urandom_range(99) >= gap_pct);
      Ld_Data  = words[idx];
      Ld_Last  = use_last && (idx == n - 1);
      @(negedge Clk);
      checks++;
      if (Sram_En !== Ld_Valid || Sram_RW !== Ld_Valid || Sram_Addr !== SAW'(idx) ||
          (Ld_Valid && Sram_Data !== words[idx])) begin
        errors++;
        $display("FAIL %s_write_port: got en=%b rw=%b addr=%0d data=%h need en=rw=%b addr=%0d data=%h",
                 tag, Sram_En, Sram_RW, Sram_Addr, Sram_Data, Ld_Valid, idx, words[idx]);
      end
      if (Ld_Valid) idx++;
      @(posedge Clk); #1;
      cyc++;
    end
    Ld_Valid = 1'b0; Ld_Last = 1'b0;
    checks++;
    if (idx < n) begin
      errors++; $display("FAIL %s_load_budget: got %0d words accepted need %0d", tag, idx, n);
    end
    if (use_last || n == SLW) begin
      checks++;
      if (Gpp_Rst !== 1'b1 || Gpp_Str !== 1'b0 || Ld_Ready !== 1'b0 || Busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_grst: got rst=%b str=%b rdy=%b busy=%b need 1 0 0 1", tag, Gpp_Rst, Gpp_Str, Ld_Ready, Busy);
      end
    end
    checks++;
    begin
      int bad = (wlog.size() != n) ? 1 : 0;
      for (int i = 0; i < wlog.size() && i < n; i++)
        if (wlog[i].addr != i || wlog[i].data !== words[i]) bad++;
      if (bad != 0) begin
        errors++; $display("FAIL %s_sram_image: got %0d writes (%0d bad) need %0d at addr 0..%0d", tag, wlog.size(), bad, n, n - 1);
      end
    end
  endtask

  // From the GRST cycle: runs START and RUN, raising Gpp_Done in RUN cycle done_at
  // (out of 1..TO means never) and Boot_Req in RUN cycle req_at.
  task automatic run_phase(input int done_at, input int req_at, input string tag);
    int  exp_cyc;
    bit  exp_err;
    exp_err = !(done_at >= 1 && done_at <= TO);
    exp_cyc = exp_err ? TO : done_at;
    step();
    checks++;
    if (Gpp_Str !== 1'b1 || Gpp_Rst !== 1'b0 || Busy !== 1'b1) begin
      errors++; $display("FAIL %s_start: got str=%b rst=%b busy=%b need 1 0 1", tag, Gpp_Str, Gpp_Rst, Busy);
    end
    for (int k = 1; k <= exp_cyc; k++) begin
      step();
      Gpp_Done = (k == done_at);
      Boot_Req = (k == req_at);
      checks++;
      if (Busy !== 1'b1 || Run_Done !== 1'b0 || Gpp_Str !== 1'b1 || Gpp_Rst !== 1'b0 ||
          Run_Cycles !== 32'(k - 1)) begin
        errors++;
        $display("FAIL %s_run_c%0d: got busy=%b rd=%b str=%b rst=%b cyc=%0d need 1 0 1 0 %0d",
                 tag, k, Busy, Run_Done, Gpp_Str, Gpp_Rst, Run_Cycles, k - 1);
      end
    end
    step();
    Gpp_Done = 1'b0; Boot_Req = 1'b0;
    checks++;
    if (Run_Done !== 1'b1 || Busy !== 1'b0 || Gpp_Rst !== 1'b1 || Gpp_Str !== 1'b0) begin
      errors++; $display("FAIL %s_done_state: got rd=%b busy=%b rst=%b str=%b need 1 0 1 0", tag, Run_Done, Busy, Gpp_Rst, Gpp_Str);
    end
    checks++;
    if (Err !== exp_err) begin
      errors++; $display("FAIL %s_err: got %b need %b", tag, Err, exp_err);
    end
    checks++;
    if (Run_Cycles !== 32'(exp_cyc)) begin
      errors++; $display("FAIL %s_run_cycles: got %0d need %0d", tag, Run_Cycles, exp_cyc);
    end
    step(); step();
    checks++;
    if (Run_Cycles !== 32'(exp_cyc) || Run_Done !== 1'b1 || Err !== exp_err) begin
      errors++; $display("FAIL %s_done_sticky: got cyc=%0d rd=%b err=%b need %0d 1 %b", tag, Run_Cycles, Run_Done, Err, exp_cyc, exp_err);
    end
  endtask

  task automatic test_short_program();
    words = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
    boot_and_load(4, 1'b1, 0, 1'b0, 16'h0, "short");
    run_phase(10, 0, "short");
  endtask

  task automatic test_backpressure();
    rand_words(3);
    boot_and_load(3, 1'b1, 0, 1'b1, 16'h0019, "gaps");
    run_phase(3, 2, "gaps_req_in_run");
  endtask

  task automatic test_timeout();
    rand_words(5);
    boot_and_load(5, 1'b1, 30, 1'b0, 16'h0, "tmo");
    run_phase(1000, 0, "tmo");
  endtask

  task automatic test_done_at_timeout();
    rand_words(2 + int'($urandom_range(4)));
    boot_and_load(words.size(), 1'b1, 20, 1'b0, 16'h0, "done_tmo");
    run_phase(TO, 0, "done_tmo");
  endtask

  task automatic test_full_fill();
    rand_words(SLW);
    boot_and_load(SLW, 1'b0, 0, 1'b0, 16'h0, "full");
    Ld_Valid = 1'b1; Ld_Data = $urandom; #1;
    checks++;
    if (Ld_Ready !== 1'b0 || Sram_En !== 1'b0) begin
      errors++; $display("FAIL full_extra_word: got rdy=%b en=%b need 0 0", Ld_Ready, Sram_En);
    end
    Ld_Valid = 1'b0;
    run_phase(1 + int'($urandom_range(TO - 2)), 0, "full");
  endtask

  task automatic test_abort_and_reboot();
    rand_words(7);
    boot_and_load(7, 1'b0, 0, 1'b0, 16'h0, "abort");
    checks++;
    if (Ld_Ready !== 1'b1 || Sram_Addr !== SAW'(7)) begin
      errors++; $display("FAIL abort_mid_load: got rdy=%b addr=%0d need 1 7", Ld_Ready, Sram_Addr);
    end
    Rst = 1'b0; #1;
    checks++;
    if (Ld_Ready !== 1'b0 || Busy !== 1'b0 || Gpp_Rst !== 1'b1 || Mem_Rst !== 1'b0 ||
        Sram_Addr !== '0 || Run_Cycles !== 32'd0) begin
      errors++;
      $display("FAIL abort_immediate: got rdy=%b busy=%b rst=%b mrst=%b addr=%0d cyc=%0d need 0 0 1 0 0 0",
               Ld_Ready, Busy, Gpp_Rst, Mem_Rst, Sram_Addr, Run_Cycles);
    end
    step(); Rst = 1'b1; step();
    rand_words(1 + int'($urandom_range(9)));
    boot_and_load(words.size(), 1'b1, 40, 1'b0, 16'h0, "reboot");
    run_phase(1 + int'($urandom_range(TO + 4)), 0, "reboot");
  endtask

  initial begin
    Rst = 1'b0; Boot_Req = 0; Ld_Valid = 0; Ld_Last = 0; Ld_Data = '0; Gpp_Done = 0;
    test_reset();
    test_short_program();
    test_backpressure();
    test_timeout();
    test_done_at_timeout();
    test_full_fill();
    test_abort_and_reboot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpp_boot_ctrl.md
# gpp_boot_ctrl

Boot sequencer for the GPP: owns the GPP's instruction-SRAM load port and its reset/start/done handshake. On a host boot request it clears the SRAM, streams instruction words into consecutive SRAM addresses from 0, pulses the GPP reset, asserts start and supervises the run until Done or timeout. It sits between the host/loader stream and `GPP_TOP`, replacing hand-driven Rst_M/Addr/En/RW/Rst/Str sequencing.

## Interface
- `D_WIDTH`, 32, instruction/data word width (from define.h)
- `SA_WIDTH`, 5, SRAM address width (from define.h)
- `SL_WIDTH`, 32, SRAM depth in words (from define.h)
- `TIMEOUT`, 100000, max RUN cycles before abort (1..2^32-1)
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- Boot_Req  in  1  start load+run; sampled only in IDLE/DONE
- Ld_Valid  in  1  loader word valid
- Ld_Data  in  D_WIDTH  loader word
- Ld_Last  in  1  marks final word of program
- Ld_Ready  out  1  controller accepts word this cycle
- Mem_Rst  out  1  SRAM clear (Rst_M), active-high
- Sram_Addr  out  SA_WIDTH  write address
- Sram_Data  out  D_WIDTH  write data
- Sram_En  out  1  SRAM enable
- Sram_RW  out  1  1 = write
- Gpp_Rst  out  1  GPP reset, active-high
- Gpp_Str  out  1  GPP start level
- Gpp_Done  in  1  GPP finished
- Busy  out  1  state not IDLE/DONE
- Run_Done  out  1  run finished (sticky until next Boot_Req)
- Err  out  1  run aborted by timeout (sticky until next Boot_Req)
- Run_Cycles  out  32  cycles spent in RUN

## Operation
- States: IDLE, CLR, LOAD, GRST, START, RUN, DONE.
- IDLE: Gpp_Rst=1, everything else 0. Boot_Req=1 -> CLR.
- CLR (1 cycle): Mem_Rst=1; write pointer, Run_Cycles, Run_Done, Err cleared -> LOAD.
- LOAD: Ld_Ready=1. Accept = Ld_Valid & Ld_Ready. On accept, same cycle: Sram_En=1, Sram_RW=1, Sram_Addr=ptr, Sram_Data=Ld_Data (combinational from Ld_Data; write lands at that edge); ptr+1. Non-accept cycles: Sram_En=Sram_RW=0, Addr holds ptr.
- LOAD exit: accept with Ld_Last=1, or accept at ptr=SL_WIDTH-1 (full fill, no Last needed) -> GRST. Ld_Ready=0 from the next cycle; further words not accepted.
- GRST (1 cycle): Gpp_Rst=1 -> START.
- START (1 cycle): Gpp_Rst=0, Gpp_Str=1 -> RUN.
- RUN: Gpp_Str=1, Gpp_Rst=0; Run_Cycles+1 each cycle. Gpp_Done=1 -> DONE, Err=0. Else if Run_Cycles reaches TIMEOUT -> DONE, Err=1.
- DONE: Gpp_Str=0, Gpp_Rst=1, Run_Done=1, Run_Cycles frozen. Boot_Req=1 -> CLR.
- Boot_Req outside IDLE/DONE ignored.
- Busy=1 in CLR..RUN.

## Timing
- Reset (Rst=0, immediate): state IDLE, Gpp_Rst=1; Mem_Rst, Sram_En, Sram_RW, Sram_Addr, Gpp_Str, Ld_Ready, Busy, Run_Done, Err = 0; Run_Cycles=0. Reset mid-load/run aborts; SRAM contents undefined until next boot.
- Boot_Req high at edge N -> Mem_Rst high N+1..N+2, Ld_Ready high from N+2.
- Last accept at edge M -> Gpp_Rst high through GRST, Gpp_Str high from M+2.
- Run_Cycles counts RUN cycles inclusive of the cycle Gpp_Done is sampled. Done and timeout on the same cycle: Done wins, Err=0.
- All outputs except Sram_Data/Sram_En/Sram_RW (combinational on Ld_Valid in LOAD) are registered/state-decoded.

## Structure
- State encoding localparams and TIMEOUT default go in define.h alongside D_WIDTH/SA_WIDTH/SL_WIDTH.
- Single module; no sub-module. Counters: SA_WIDTH+1-bit ptr, 32-bit Run_Cycles.

## Test plan
- Reset: hold Rst=0 with random inputs -> Gpp_Rst=1, all other outputs 0; Boot_Req during reset ignored.
- Short program: Boot_Req, 4 words (0x20080005, 0x20090003, 0x01095020, 0xAC0A0000) Last on 4th; Gpp_Done after 10 RUN cycles -> writes addr 0..3, one GRST cycle, Str from START, Run_Cycles=10, Run_Done=1, Err=0.
- Full fill: 32 words, Ld_Last never asserted, Ld_Valid held high -> writes addr 0..31, 33rd word not accepted (Ld_Ready=0), proceeds to GRST.
- Backpressure gaps: Ld_Valid toggles 1,0,0,1,1 -> Sram_En only on valid cycles, addresses 0,1,2 contiguous.
- Timeout: TIMEOUT=16, Gpp_Done held 0 -> DONE after 16 RUN cycles, Err=1, Run_Cycles=16, Gpp_Rst=1; Done+timeout same cycle -> Err=0.
- Abort/rebooting: Rst low mid-LOAD at ptr=7 -> immediate reset values; Boot_Req in RUN ignored; Boot_Req in DONE clears Run_Done/Err, reloads from addr 0.
